// File: rtl/sector_index_sequencer_pkg.sv
// Shared state encoding and RK05 default timing constants for the sector/index sequencer.
// Used by sector_index_sequencer and its pulse stretcher.
package sector_index_sequencer_pkg;

    typedef enum logic {ST_IDLE, ST_RUN} seq_state_t;

    localparam int unsigned SYS_CLKS_PER_US       = 20;    // 20 MHz system clock
    localparam int unsigned RK05_SECTORS          = 12;
    localparam int unsigned RK05_SECTOR_PERIOD_US = 3333;
    localparam int unsigned RK05_PULSE_US         = 2;
    localparam int unsigned RK05_INDEX_OFFSET_US  = 2733;

    function automatic logic [15:0] clamp_period(input logic [15:0] req,
                                                 input logic [15:0] min_period);
        return (req < min_period) ? min_period : req;
    endfunction

endpackage

// File: rtl/sector_index_sequencer_pulse_stretcher.sv
// Fixed-width pulse generator: loads on trigger, counts down, output high while nonzero.
// Clear aborts a pulse in progress on the next clock.
module sector_index_sequencer_pulse_stretcher #(
    parameter int unsigned PulseClks = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic trigger,
    output logic pulse
);

    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (trigger) begin
            count_d = 16'(PulseClks);
        end else if (count_q != '0) begin
            count_d = count_q - 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign pulse = (count_q != '0);

endmodule

// File: rtl/sector_index_sequencer.sv
// RK05 platter rotation timing: sector counter, sector/index pulses, sector-start strobe.
// Define SECTOR_PERIOD_PROG_EN to take the slot period from the sector_period_us port.
module sector_index_sequencer
    import sector_index_sequencer_pkg::*;
#(
    parameter int unsigned CLKS_PER_US      = SYS_CLKS_PER_US,
    parameter int unsigned SECTORS          = RK05_SECTORS,
    parameter int unsigned SECTOR_PERIOD_US = RK05_SECTOR_PERIOD_US,
    parameter int unsigned PULSE_WIDTH_US   = RK05_PULSE_US,
    parameter int unsigned INDEX_OFFSET_US  = RK05_INDEX_OFFSET_US
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        spin_enable,
`ifdef SECTOR_PERIOD_PROG_EN
    input  logic [15:0] sector_period_us,
`endif
    output logic [3:0]  Sector_Address,
    output logic        bus_sector_pulse,
    output logic        bus_index_pulse,
    output logic        sector_start,
    output logic [15:0] revolution_count
);

    localparam logic [3:0]  LAST_SECTOR = 4'(SECTORS - 1);
    localparam logic [15:0] PRESC_MAX   = 16'(CLKS_PER_US - 1);
    localparam logic [15:0] INDEX_AT    = 16'(INDEX_OFFSET_US - 1);
    localparam logic [15:0] MIN_PERIOD  = 16'(INDEX_OFFSET_US + PULSE_WIDTH_US + 1);
    localparam int unsigned PULSE_CLKS  = PULSE_WIDTH_US * CLKS_PER_US;

    if (SECTORS < 2 || SECTORS > 16) begin : g_bad_sectors
        $error("SECTORS must lie in 2..16");
    end
    if (INDEX_OFFSET_US + PULSE_WIDTH_US >= SECTOR_PERIOD_US) begin : g_bad_offset
        $error("INDEX_OFFSET_US must be below SECTOR_PERIOD_US - PULSE_WIDTH_US");
    end

    seq_state_t  state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  sector_q, sector_d;
    logic        start_q, start_d;
    logic [15:0] rev_q, rev_d;
    logic [15:0] period;
    logic        us_tick, slot_wrap, index_trig;

`ifdef SECTOR_PERIOD_PROG_EN
    logic [15:0] period_q, period_d;
    logic        sample;

    // Modulus only changes at slot boundaries so a slot never gets cut short.
    always_comb begin
        sample   = spin_enable && (state_q == ST_IDLE || slot_wrap);
        period_d = sample ? clamp_period(sector_period_us, MIN_PERIOD) : period_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            period_q <= 16'(SECTOR_PERIOD_US);
        end else begin
            period_q <= period_d;
        end
    end

    assign period = period_q;
`else
    assign period = 16'(SECTOR_PERIOD_US);
`endif

    always_comb begin
        state_d    = spin_enable ? ST_RUN : ST_IDLE;
        presc_d    = presc_q;
        timer_d    = timer_q;
        sector_d   = sector_q;
        start_d    = 1'b0;
        index_trig = 1'b0;
        us_tick    = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
        slot_wrap  = us_tick && (timer_q == period - 16'd1);

        if (!spin_enable) begin
            presc_d  = '0;
            timer_d  = '0;
            sector_d = LAST_SECTOR;
        end else if (state_q == ST_IDLE) begin
            // Idle parks on the last sector, so the first strobe reports sector 0.
            presc_d  = '0;
            timer_d  = '0;
            sector_d = '0;
            start_d  = 1'b1;
        end else begin
            presc_d = us_tick ? '0 : presc_q + 16'd1;
            if (us_tick) begin
                timer_d = slot_wrap ? '0 : timer_q + 16'd1;
            end
            if (slot_wrap) begin
                start_d  = 1'b1;
                sector_d = (sector_q == LAST_SECTOR) ? '0 : sector_q + 4'd1;
            end
            index_trig = us_tick && (sector_q == LAST_SECTOR) && (timer_q == INDEX_AT);
        end

        rev_d = rev_q + 16'(index_trig);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            timer_q  <= '0;
            sector_q <= LAST_SECTOR;
            start_q  <= 1'b0;
            rev_q    <= '0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            timer_q  <= timer_d;
            sector_q <= sector_d;
            start_q  <= start_d;
            rev_q    <= rev_d;
        end
    end

    sector_index_sequencer_pulse_stretcher #(
        .PulseClks (PULSE_CLKS)
    ) u_sector_pulse (
        .clock   (clock),
        .reset   (reset),
        .clear   (!spin_enable),
        .trigger (start_d),
        .pulse   (bus_sector_pulse)
    );

    sector_index_sequencer_pulse_stretcher #(
        .PulseClks (PULSE_CLKS)
    ) u_index_pulse (
        .clock   (clock),
        .reset   (reset),
        .clear   (!spin_enable),
        .trigger (index_trig),
        .pulse   (bus_index_pulse)
    );

    assign Sector_Address   = sector_q;
    assign sector_start     = start_q;
    assign revolution_count = rev_q;

endmodule

// File: tb/tb_sector_index_sequencer.sv
// Directed bench for sector_index_sequencer with small timing (2 clk/us, 4 sectors, 10 us slots).
// Build with SECTOR_PERIOD_PROG_EN to also exercise the programmable slot period.
module tb_sector_index_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        spin_enable = 1'b0;
    logic [3:0]  Sector_Address;
    logic        bus_sector_pulse;
    logic        bus_index_pulse;
    logic        sector_start;
    logic [15:0] revolution_count;
`ifdef SECTOR_PERIOD_PROG_EN
    logic [15:0] sector_period_us = 16'd10;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    sector_index_sequencer #(
        .CLKS_PER_US      (2),
        .SECTORS          (4),
        .SECTOR_PERIOD_US (10),
        .PULSE_WIDTH_US   (2),
        .INDEX_OFFSET_US  (5)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .spin_enable      (spin_enable),
`ifdef SECTOR_PERIOD_PROG_EN
        .sector_period_us (sector_period_us),
`endif
        .Sector_Address   (Sector_Address),
        .bus_sector_pulse (bus_sector_pulse),
        .bus_index_pulse  (bus_index_pulse),
        .sector_start     (sector_start),
        .revolution_count (revolution_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packed view: {rev[15:0], sector[3:0], start, sector pulse, index pulse}.
    function automatic logic [31:0] vec(input int rev, input int sec, input bit st,
                                        input bit sp, input bit ip);
        return {9'd0, 16'(rev), 4'(sec), st, sp, ip};
    endfunction

    function automatic logic [31:0] obs();
        return {9'd0, revolution_count, Sector_Address, sector_start, bus_sector_pulse,
                bus_index_pulse};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int overlap;
        overlap = 0;

        repeat (3) @(negedge clock);
        check("reset_sector", 32'(Sector_Address), 32'd3);
        check("reset_spulse", 32'(bus_sector_pulse), 32'd0);
        check("reset_ipulse", 32'(bus_index_pulse), 32'd0);
        check("reset_start", 32'(sector_start), 32'd0);
        check("reset_rev", 32'(revolution_count), 32'd0);

        reset = 1'b0;
        @(negedge clock);
        check("idle_hold", obs(), vec(0, 3, 0, 0, 0));

        // Spin up and trace five slots; step k observes the state after the (k-1)th run edge.
        spin_enable = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            int p;
            int s;
            @(negedge clock);
            p = (k - 1) % 20;
            s = ((k - 1) / 20) % 4;
            check($sformatf("run_k%0d", k), obs(),
                  vec((k >= 71) ? 1 : 0, s, p == 0, p < 4, s == 3 && p >= 10 && p < 14));
            if (bus_sector_pulse && bus_index_pulse) overlap++;
        end
        check("no_overlap", 32'(overlap), 32'd0);

        @(negedge clock);
        check("sector1_start", obs(), vec(1, 1, 1, 1, 0));

        // Drop spin while the sector pulse is high.
        spin_enable = 1'b0;
        @(negedge clock);
        check("drop_spin", obs(), vec(1, 3, 0, 0, 0));
        @(negedge clock);
        check("idle_after_drop", obs(), vec(1, 3, 0, 0, 0));

        spin_enable = 1'b1;
        @(negedge clock);
        check("respin", obs(), vec(1, 0, 1, 1, 0));
        repeat (44) @(negedge clock);
        check("mid_sector2", obs(), vec(1, 2, 0, 0, 0));

        reset = 1'b1;
        @(negedge clock);
        check("reset_in_run", obs(), vec(0, 3, 0, 0, 0));
        reset = 1'b0;
        @(negedge clock);
        check("restart_after_reset", obs(), vec(0, 0, 1, 1, 0));

`ifdef SECTOR_PERIOD_PROG_EN
        begin
            int strobes[$];
            int exp_k[4];
            exp_k = '{21, 61, 101, 117};
            for (int k = 2; k <= 130; k++) begin
                @(negedge clock);
                if (sector_start) strobes.push_back(k);
                if (k == 5) sector_period_us = 16'd20;
                if (k == 65) sector_period_us = 16'd3;
            end
            check("prog_strobe_count", 32'(strobes.size()), 32'd4);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("prog_strobe%0d", i),
                      (i < strobes.size()) ? 32'(strobes[i]) : 32'hFFFF_FFFF, 32'(exp_k[i]));
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
